// File: rtl/kb_pkg.sv
// Shared types and helpers for the keypad scan controller.
//   kb_state_t : scan sequencer states
//   key_code_t : {row, col} key code payload
//   col_encode : priority encoder for the active-low column lines
package kb_pkg;

    localparam int unsigned ROW_W  = 3;
    localparam int unsigned COL_W  = 2;
    localparam int unsigned CODE_W = ROW_W + COL_W;

    localparam logic [1:3] CO_IDLE = 3'b111;

    typedef enum logic [1:0] {
        SCAN    = 2'd0,
        CONFIRM = 2'd1,
        PRESSED = 2'd2
    } kb_state_t;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } key_code_t;

    // Lowest asserted (low) column wins: Co[1] -> 0, Co[2] -> 1, Co[3] -> 2.
    function automatic logic [COL_W-1:0] col_encode(input logic [1:3] co);
        if (!co[1]) begin
            return COL_W'(0);
        end else if (!co[2]) begin
            return COL_W'(1);
        end else begin
            return COL_W'(2);
        end
    endfunction

endpackage

// File: rtl/kb_scan_div.sv
// Scan tick generator: one-cycle tick every SCAN_DIV clocks.
//   Clk10M : clock
//   Clr    : async active-high clear
//   tick_c : high for the cycle where the divider sits at SCAN_DIV-1
module kb_scan_div #(
    parameter int unsigned SCAN_DIV = 8
) (
    input  logic Clk10M,
    input  logic Clr,
    output logic tick_c
);

    localparam int unsigned     DIV_W    = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div_cnt;

    assign tick_c = (div_cnt == DIV_LAST);

    // Free-running modulo-SCAN_DIV counter.
    always_ff @(posedge Clk10M or posedge Clr) begin
        if (Clr) begin
            div_cnt <= '0;
        end else if (tick_c) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/kb_scan_ctrl.sv
// 8x3 keypad scan sequencer with press/release debounce and valid/ack output.
//   Clk10M, Clr : clock, async active-high reset
//   Co          : active-low column lines (3'b111 = no key)
//   De          : row-select code, frozen while a key is confirmed or held
//   Key_Code    : {row, col} of the last accepted key
//   Key_Valid   : key code pending, cleared by Key_Ack
//   Key_Ack     : consumer acknowledge
//   Key_Down    : a confirmed key is held
//   Overrun     : sticky, a key was confirmed while Key_Valid was pending
module kb_scan_ctrl
    import kb_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 8,
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic              Clk10M,
    input  logic              Clr,
    input  logic [1:3]        Co,
    output logic [3:1]        De,
    output logic [CODE_W-1:0] Key_Code,
    output logic              Key_Valid,
    input  logic              Key_Ack,
    output logic              Key_Down,
    output logic              Overrun
);

    localparam int unsigned      CNT_W   = $clog2(DEBOUNCE + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE);

    logic tick_c;

    kb_scan_div #(.SCAN_DIV(SCAN_DIV)) u_div (
        .Clk10M (Clk10M),
        .Clr    (Clr),
        .tick_c (tick_c)
    );

    kb_state_t        state_q, state_n;
    logic [ROW_W-1:0] de_q, de_n;
    key_code_t        key_q, key_n;
    key_code_t        code_q, code_n;
    logic [CNT_W-1:0] press_q, press_n;
    logic [CNT_W-1:0] rel_q, rel_n;
    logic             valid_q, valid_n;
    logic             down_q, down_n;
    logic             ovr_q, ovr_n;

    logic             col_bit;
    logic             confirm;
    key_code_t        conf_key;
    logic [CNT_W-1:0] press_inc;
    logic [CNT_W-1:0] rel_inc;

    // State register.
    always_ff @(posedge Clk10M or posedge Clr) begin
        if (Clr) begin
            state_q <= SCAN;
            de_q    <= '0;
            key_q   <= '0;
            code_q  <= '0;
            press_q <= '0;
            rel_q   <= '0;
            valid_q <= 1'b0;
            down_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            de_q    <= de_n;
            key_q   <= key_n;
            code_q  <= code_n;
            press_q <= press_n;
            rel_q   <= rel_n;
            valid_q <= valid_n;
            down_q  <= down_n;
            ovr_q   <= ovr_n;
        end
    end

    // Next-state: scan/debounce on ticks, handshake on every edge.
    always_comb begin
        state_n  = state_q;
        de_n     = de_q;
        key_n    = key_q;
        code_n   = code_q;
        press_n  = press_q;
        rel_n    = rel_q;
        valid_n  = valid_q;
        down_n   = down_q;
        ovr_n    = ovr_q;
        confirm  = 1'b0;
        conf_key = key_q;

        // Column line of the latched key (active-low).
        case (key_q.col)
            COL_W'(0): col_bit = Co[1];
            COL_W'(1): col_bit = Co[2];
            default:   col_bit = Co[3];
        endcase

        press_inc = (press_q == CNT_MAX) ? CNT_MAX : press_q + CNT_W'(1);
        rel_inc   = (rel_q   == CNT_MAX) ? CNT_MAX : rel_q   + CNT_W'(1);

        if (Key_Ack && valid_q) begin
            valid_n = 1'b0;
            ovr_n   = 1'b0;
        end

        if (tick_c) begin
            case (state_q)
                SCAN: begin
                    if (Co == CO_IDLE) begin
                        de_n = de_q + ROW_W'(1);
                    end else begin
                        key_n.row = de_q;
                        key_n.col = col_encode(Co);
                        conf_key  = key_n;
                        press_n   = CNT_W'(1);
                        if (DEBOUNCE == 1) begin
                            confirm = 1'b1;
                        end else begin
                            state_n = CONFIRM;
                        end
                    end
                end
                CONFIRM: begin
                    if (!col_bit) begin
                        press_n = press_inc;
                        if (press_inc == CNT_MAX) begin
                            confirm = 1'b1;
                        end
                    end else begin
                        press_n = '0;
                        de_n    = de_q + ROW_W'(1);
                        state_n = SCAN;
                    end
                end
                PRESSED: begin
                    if (col_bit) begin
                        if (rel_inc == CNT_MAX) begin
                            rel_n   = '0;
                            down_n  = 1'b0;
                            de_n    = de_q + ROW_W'(1);
                            state_n = SCAN;
                        end else begin
                            rel_n = rel_inc;
                        end
                    end else begin
                        rel_n = '0;
                    end
                end
                default: state_n = SCAN;
            endcase
        end

        // A same-edge Ack frees the slot, so the new code is still accepted.
        if (confirm) begin
            state_n = PRESSED;
            down_n  = 1'b1;
            rel_n   = '0;
            if (!valid_q || Key_Ack) begin
                code_n  = conf_key;
                valid_n = 1'b1;
            end else begin
                ovr_n = 1'b1;
            end
        end
    end

    assign De        = de_q;
    assign Key_Code  = code_q;
    assign Key_Valid = valid_q;
    assign Key_Down  = down_q;
    assign Overrun   = ovr_q;

endmodule

// File: tb/tb_kb_scan_ctrl.sv
// Directed bench for kb_scan_ctrl (SCAN_DIV=8, DEBOUNCE=3, 200 ns clock).
module tb_kb_scan_ctrl;

    logic       Clk10M = 1'b0;
    logic       Clr;
    logic [1:3] Co;
    logic [3:1] De;
    logic [4:0] Key_Code;
    logic       Key_Valid;
    logic       Key_Ack;
    logic       Key_Down;
    logic       Overrun;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int cyc    = 0;

    always #100 Clk10M = ~Clk10M;

    kb_scan_ctrl #(.SCAN_DIV(8), .DEBOUNCE(3)) dut (
        .Clk10M    (Clk10M),
        .Clr       (Clr),
        .Co        (Co),
        .De        (De),
        .Key_Code  (Key_Code),
        .Key_Valid (Key_Valid),
        .Key_Ack   (Key_Ack),
        .Key_Down  (Key_Down),
        .Overrun   (Overrun)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n scan ticks; tick edges fall on every 8th edge after Clr release.
    task automatic to_tick(input int n);
        for (int i = 0; i < n; i++) begin
            do begin
                @(posedge Clk10M);
                cyc++;
            end while (cyc % 8 != 0);
        end
        #1;
    endtask

    task automatic edge1();
        @(posedge Clk10M);
        cyc++;
        #1;
    endtask

    initial begin
        Clr     = 1'b1;
        Co      = 3'b111;
        Key_Ack = 1'b0;
        #250;
        check("rst_de",    8'(De),        8'h00);
        check("rst_code",  8'(Key_Code),  8'h00);
        check("rst_valid", 8'(Key_Valid), 8'h00);
        check("rst_down",  8'(Key_Down),  8'h00);
        check("rst_ovr",   8'(Overrun),   8'h00);
        #35;
        Clr = 1'b0;
        cyc = 0;

        // Free scan: De holds until the 8th edge, then steps every tick.
        repeat (7) edge1();
        check("s1_de_pre_tick", 8'(De), 8'h00);
        for (int i = 1; i <= 8; i++) begin
            to_tick(1);
            check("s1_de_step", 8'(De), 8'(i % 8));
        end
        check("s1_valid", 8'(Key_Valid), 8'h00);
        check("s1_down",  8'(Key_Down),  8'h00);
        check("s1_ovr",   8'(Overrun),   8'h00);

        // Clean press at De=1, col 1.
        to_tick(1);
        check("s2_de1", 8'(De), 8'h01);
        Co = 3'b101;
        to_tick(1);
        check("s2_de_frozen_det", 8'(De), 8'h01);
        check("s2_valid_det",     8'(Key_Valid), 8'h00);
        to_tick(1);
        check("s2_valid_cnt2",    8'(Key_Valid), 8'h00);
        to_tick(1);
        check("s2_valid", 8'(Key_Valid), 8'h01);
        check("s2_code",  8'(Key_Code),  8'h05);
        check("s2_down",  8'(Key_Down),  8'h01);
        check("s2_de_frozen", 8'(De), 8'h01);
        Key_Ack = 1'b1;
        edge1();
        Key_Ack = 1'b0;
        check("s2_ack_valid", 8'(Key_Valid), 8'h00);
        Co = 3'b111;
        to_tick(2);
        check("s2_down_rel2", 8'(Key_Down), 8'h01);
        check("s2_de_rel2",   8'(De),       8'h01);
        to_tick(1);
        check("s2_down_rel3", 8'(Key_Down), 8'h00);
        check("s2_de_next",   8'(De),       8'h02);

        // One-tick bounce at De=3 is abandoned.
        to_tick(1);
        check("s3_de3", 8'(De), 8'h03);
        Co = 3'b110;
        to_tick(1);
        check("s3_de_hold", 8'(De), 8'h03);
        Co = 3'b111;
        to_tick(1);
        check("s3_de_resume", 8'(De),        8'h04);
        check("s3_valid",     8'(Key_Valid), 8'h00);
        check("s3_down",      8'(Key_Down),  8'h00);

        // Two columns low at De=6: Co[1] wins -> col 0.
        to_tick(2);
        check("s4_de6", 8'(De), 8'h06);
        Co = 3'b001;
        to_tick(3);
        check("s4_valid", 8'(Key_Valid), 8'h01);
        check("s4_code",  8'(Key_Code),  8'h18);
        Key_Ack = 1'b1;
        edge1();
        Key_Ack = 1'b0;
        Co = 3'b111;
        to_tick(3);
        check("s4_down", 8'(Key_Down), 8'h00);
        check("s4_de7",  8'(De),       8'h07);

        // Overrun: second key confirmed while the first is still pending.
        to_tick(1);
        check("s5_de0", 8'(De), 8'h00);
        Co = 3'b011;
        to_tick(3);
        check("s5_valid1", 8'(Key_Valid), 8'h01);
        check("s5_code1",  8'(Key_Code),  8'h00);
        check("s5_ovr0",   8'(Overrun),   8'h00);
        Co = 3'b111;
        to_tick(3);
        check("s5_de1", 8'(De), 8'h01);
        to_tick(1);
        check("s5_de2", 8'(De), 8'h02);
        Co = 3'b110;
        to_tick(3);
        check("s5_ovr",   8'(Overrun),   8'h01);
        check("s5_code",  8'(Key_Code),  8'h00);
        check("s5_valid", 8'(Key_Valid), 8'h01);
        check("s5_down",  8'(Key_Down),  8'h01);
        Key_Ack = 1'b1;
        edge1();
        Key_Ack = 1'b0;
        check("s5_ack_valid", 8'(Key_Valid), 8'h00);
        check("s5_ack_ovr",   8'(Overrun),   8'h00);
        Co = 3'b111;
        to_tick(3);
        check("s5_de3", 8'(De), 8'h03);

        // Async Clr while confirming at De=5.
        to_tick(2);
        check("s6_de5", 8'(De), 8'h05);
        Co = 3'b110;
        to_tick(1);
        check("s6_de_frozen", 8'(De), 8'h05);
        edge1();
        #50;
        Clr = 1'b1;
        #1;
        check("s6_clr_de",    8'(De),        8'h00);
        check("s6_clr_valid", 8'(Key_Valid), 8'h00);
        check("s6_clr_down",  8'(Key_Down),  8'h00);
        check("s6_clr_ovr",   8'(Overrun),   8'h00);
        check("s6_clr_code",  8'(Key_Code),  8'h00);
        @(posedge Clk10M);
        @(posedge Clk10M);
        Co = 3'b111;
        #100;
        Clr = 1'b0;
        cyc = 0;
        check("s6_de_after", 8'(De), 8'h00);
        to_tick(1);
        check("s6_de_restart", 8'(De),        8'h01);
        check("s6_valid",      8'(Key_Valid), 8'h00);
        to_tick(1);
        check("s6_de_next", 8'(De), 8'h02);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
